sram_access_controller: RTL and testbench
=========================================

Name: sram_access_controller

Overview:
- Initiator-side controller that drives the CEB/WEB/A/D/M/Q port of a single-port TSMC-style SRAM macro.
- Accepts read/write requests on a valid/ready interface and issues at most one SRAM access per cycle.
- Captures read data (1-cycle SRAM latency) into a response FIFO presented on a valid/ready response interface.
- Includes a zero-fill sequencer that clears the whole array after power-up.

Parameters:
WIDTH, 128, data/mask width in bits
NUM_ROWS, 4096, SRAM depth; AddressWidth = $clog2(NUM_ROWS) (localparam)
RESP_DEPTH, 2, response FIFO entries (>=1); also the maximum reads outstanding plus buffered

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  asynchronous reset, active-high
init_start  input  1  pulse: begin zero-fill (honoured only in IDLE)
init_busy  output  1  high while zero-fill in progress
init_done  output  1  one-cycle pulse after last fill write
req_valid  input  1  request valid
req_ready  output  1  request accepted when valid&ready
req_write  input  1  1=write, 0=read
req_addr  input  AddressWidth  row address
req_wdata  input  WIDTH  write data
req_mask  input  WIDTH  write bit mask, 1=overwrite
rsp_valid  output  1  read response valid
rsp_ready  input  1  consumer ready
rsp_rdata  output  WIDTH  read data (FIFO head)
sram_ceb  output  1  SRAM chip enable, active-low
sram_web  output  1  SRAM write enable, active-low
sram_a  output  AddressWidth  SRAM address
sram_d  output  WIDTH  SRAM write data
sram_m  output  WIDTH  SRAM write mask
sram_q  input  WIDTH  SRAM registered read data

Behaviour:
- Reset (async, RST=1): state IDLE, FIFO empty, inflight=0, fill counter 0.
  - Outputs forced: req_ready=0, rsp_valid=0, init_busy=0, init_done=0, sram_ceb=1, sram_web=1, sram_a=0, sram_d=0, sram_m=0.
  - SRAM contents are untouched.
- States: IDLE, FILL.
- IDLE:
  - req_ready = !init_start & (req_write | (occupancy + inflight < RESP_DEPTH)).
  - occupancy is the FIFO count before this cycle's pop; a same-cycle pop does not free a credit.
- Access issue:
  - The SRAM port is driven combinationally in the handshake cycle: sram_ceb=0, sram_web=!req_write, sram_a=req_addr, sram_d=req_wdata, sram_m=req_mask.
  - The SRAM samples the access on the edge that completes the handshake.
  - With no handshake: sram_ceb=1, sram_web=1.
- Read pipeline:
  - Read accepted at edge k sets inflight.
  - At edge k+1, sram_q is pushed into the FIFO and inflight clears.
  - rsp_valid rises after edge k+1, i.e. 2 cycles after the request cycle.
- Writes produce no response. sram_q after a write (old data) is ignored.
- Ordering: responses are in read-issue order.
  - A read followed by a write to the same row in the next cycle returns the pre-write data.
  - A write followed by a read returns the written data.
- FIFO:
  - rsp_valid = !empty; rsp_rdata = head.
  - Pop on rsp_valid&rsp_ready. Push and pop may coincide.
  - Overflow is impossible by credit rule; an overflow is an assertion failure.
- FILL:
  - init_start=1 in IDLE moves to FILL on the next edge. It takes priority over a same-cycle req_valid (req_ready=0 that cycle).
  - In FILL: req_ready=0, init_busy=1.
  - Each cycle drives sram_ceb=0, sram_web=0, sram_a=counter, sram_d=0, sram_m=all-ones; counter increments.
  - After address NUM_ROWS-1 is written: return to IDLE, counter to 0, init_done=1 for exactly the following cycle.
  - Fill takes exactly NUM_ROWS cycles. init_start during FILL is ignored.
  - Pending reads and FIFO contents are preserved across FILL; rsp side keeps draining.
- Reset mid-operation: fill aborts, in-flight read and FIFO contents are discarded, no init_done.

Test Plan:
1. Write row 3 = 0xA5A5…A5, mask all-ones; read row 3 next cycle -> rsp_valid 2 cycles after read handshake, rsp_rdata=0xA5A5…A5.
2. Row 5 = all-ones; masked write D=0, M=0x00FF (low byte) -> read row 5 returns all-ones except low 8 bits = 0x00.
3. RESP_DEPTH=2, rsp_ready=0, three back-to-back reads -> first two accepted, third sees req_ready=0; raise rsp_ready for one cycle -> third accepted on the following cycle; data returned in order.
4. NUM_ROWS=16, init_start pulse -> init_busy high 16 cycles, sram_a 0..15 with sram_web=0, sram_m all-ones, then init_done single pulse; subsequent reads of all rows return 0.
5. init_start and req_valid (write) in same cycle -> req_ready=0, write not issued, FILL entered; write accepted in first IDLE cycle after init_done.
6. Assert RST at fill cycle 7 with one response buffered -> immediately sram_ceb=1, rsp_valid=0, init_busy=0; no init_done afterwards; after release, IDLE with req_ready=1.

Source files
------------

// File: rtl/sram_access_controller.sv
// ---------------------------------------------------------------------------
// sram_access_controller
//
// Initiator-side controller for a single-port SRAM macro (CEB/WEB/A/D/M/Q).
// Requests arrive on a valid/ready interface and are issued to the SRAM in
// the handshake cycle, at most one access per cycle. Read data returns one
// cycle later on sram_q. It is captured into a small response FIFO that is
// presented on a valid/ready response interface. A zero-fill sequencer can
// clear the whole array, one row per cycle.
//
// Ports
//   CLK, RST        clock (rising edge), asynchronous active-high reset
//   init_start      pulse: start zero-fill (honoured only when idle)
//   init_busy       high while the zero-fill is running
//   init_done       one-cycle pulse after the last fill write
//   req_*           request channel (write flag, row address, data, bit mask)
//   rsp_*           response channel (read data, FIFO head)
//   sram_ceb/web    SRAM chip/write enable, active-low
//   sram_a/d/m      SRAM address, write data, write bit mask (1 = overwrite)
//   sram_q          SRAM registered read data
// ---------------------------------------------------------------------------
module sram_access_controller #(
   parameter int WIDTH      = 128,
   parameter int NUM_ROWS   = 4096,
   parameter int RESP_DEPTH = 2,
   localparam int AddressWidth = $clog2(NUM_ROWS)
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    init_start,
   output logic                    init_busy,
   output logic                    init_done,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [AddressWidth-1:0] req_addr,
   input  logic [WIDTH-1:0]        req_wdata,
   input  logic [WIDTH-1:0]        req_mask,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [WIDTH-1:0]        rsp_rdata,
   output logic                    sram_ceb,
   output logic                    sram_web,
   output logic [AddressWidth-1:0] sram_a,
   output logic [WIDTH-1:0]        sram_d,
   output logic [WIDTH-1:0]        sram_m,
   input  logic [WIDTH-1:0]        sram_q
);

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

   localparam int CW = $clog2(RESP_DEPTH + 1);
   localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam logic [AddressWidth-1:0] LAST_ROW  = AddressWidth'(NUM_ROWS - 1);
   localparam logic [CW:0]             DEPTH_L   = (CW + 1)'(RESP_DEPTH);
   localparam logic [CW-1:0]           FULL_CNT  = CW'(RESP_DEPTH);
   localparam logic [PW-1:0]           LAST_SLOT = PW'(RESP_DEPTH - 1);

   state_t                  state_q, state_d;
   logic [AddressWidth-1:0] fill_cnt_q, fill_cnt_d;
   logic                    init_done_q, init_done_d;
   logic                    inflight_q, inflight_d;
   logic [CW-1:0]           count_q, count_d;
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0]        fifo_mem_q [RESP_DEPTH];

   logic [CW:0]             credits_used;
   logic                    req_hs;
   logic                    push;
   logic                    pop;

   // A read needs a FIFO slot reserved for its data; both buffered entries
   // and the read still in the SRAM pipeline hold a credit. The count is
   // taken before any same-cycle pop, so a pop never frees a credit early.
   assign credits_used = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};

   // RST gates ready so no access can be issued while reset is held.
   assign req_ready = !RST && (state_q == IDLE) && !init_start &&
                      (req_write || (credits_used < DEPTH_L));
   assign req_hs    = req_valid && req_ready;

   assign init_busy = (state_q == FILL);
   assign init_done = init_done_q;

   assign rsp_valid = (count_q != '0);
   assign rsp_rdata = fifo_mem_q[rd_ptr_q];

   // The read issued last cycle has its data on sram_q now.
   assign push = inflight_q;
   assign pop  = rsp_valid && rsp_ready;

   // SRAM port: fill writes own the port; otherwise an access goes out only
   // in the cycle its handshake completes.
   always_comb begin
      sram_ceb = 1'b1;
      sram_web = 1'b1;
      sram_a   = '0;
      sram_d   = '0;
      sram_m   = '0;
      if (state_q == FILL) begin
         sram_ceb = 1'b0;
         sram_web = 1'b0;
         sram_a   = fill_cnt_q;
         sram_m   = '1;
      end else if (req_hs) begin
         sram_ceb = 1'b0;
         sram_web = !req_write;
         sram_a   = req_addr;
         sram_d   = req_wdata;
         sram_m   = req_mask;
      end
   end

   // Fill sequencer next state.
   always_comb begin
      state_d     = state_q;
      fill_cnt_d  = fill_cnt_q;
      init_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (init_start) begin
               state_d    = FILL;
               fill_cnt_d = '0;
            end
         end
         FILL: begin
            if (fill_cnt_q == LAST_ROW) begin
               state_d     = IDLE;
               fill_cnt_d  = '0;
               init_done_d = 1'b1;
            end else begin
               fill_cnt_d = fill_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Read pipeline and response FIFO pointers.
   always_comb begin
      inflight_d = req_hs && !req_write;

      wr_ptr_d = wr_ptr_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + 1'b1;
      end

      rd_ptr_d = rd_ptr_q;
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == LAST_SLOT) ? '0 : rd_ptr_q + 1'b1;
      end

      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         fill_cnt_q  <= '0;
         init_done_q <= 1'b0;
         inflight_q  <= 1'b0;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
      end else begin
         state_q     <= state_d;
         fill_cnt_q  <= fill_cnt_d;
         init_done_q <= init_done_d;
         inflight_q  <= inflight_d;
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
      end
   end

   // FIFO storage carries no reset; occupancy is tracked by count_q.
   always_ff @(posedge CLK) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= sram_q;
      end
   end

   // The credit rule must make a push into a full FIFO impossible.
   a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
      !(push && !pop && (count_q == FULL_CNT)));

endmodule

// File: tb/tb_sram_access_controller.sv
// ---------------------------------------------------------------------------
// Testbench for sram_access_controller: behavioural SRAM, a transaction-level
// reference model checked every cycle, and directed scenarios with literal
// expectations.
// ---------------------------------------------------------------------------
module tb_sram_access_controller;
   localparam int W  = 32;
   localparam int NR = 16;
   localparam int RD = 2;
   localparam int AW = 4;

   logic          CLK = 1'b0;
   logic          RST;
   logic          init_start;
   logic          init_busy;
   logic          init_done;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [W-1:0]  req_wdata;
   logic [W-1:0]  req_mask;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [W-1:0]  rsp_rdata;
   logic          sram_ceb;
   logic          sram_web;
   logic [AW-1:0] sram_a;
   logic [W-1:0]  sram_d;
   logic [W-1:0]  sram_m;
   logic [W-1:0]  sram_q;

   always #5 CLK = ~CLK;

   sram_access_controller #(
      .WIDTH      (W),
      .NUM_ROWS   (NR),
      .RESP_DEPTH (RD)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .init_start (init_start),
      .init_busy  (init_busy),
      .init_done  (init_done),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_mask   (req_mask),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .sram_ceb   (sram_ceb),
      .sram_web   (sram_web),
      .sram_a     (sram_a),
      .sram_d     (sram_d),
      .sram_m     (sram_m),
      .sram_q     (sram_q)
   );

   // Behavioural single-port SRAM with registered read data.
   logic [W-1:0] sram_mem [NR];
   initial begin
      sram_q = '0;
      forever begin
         @(posedge CLK);
         if (sram_ceb === 1'b0) begin
            if (sram_web === 1'b0)
               sram_mem[sram_a] <= (sram_mem[sram_a] & ~sram_m) | (sram_d & sram_m);
            else
               sram_q <= sram_mem[sram_a];
         end
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: golden row contents, queue of expected responses with
   // the cycle from which each must be visible, and remaining fill rows.
   typedef struct {
      logic [W-1:0] data;
      int           vfrom;
   } rsp_t;

   rsp_t         exp_q[$];
   logic [W-1:0] got_q[$];
   logic [W-1:0] gold [NR];
   int           fill_left = 0;
   bit           done_flag = 1'b0;
   int           cyc = 0;

   task automatic model_step();
      bit   er, ev, hs, ended;
      rsp_t e;
      if (RST) begin
         chk("rst_req_ready", W'(req_ready), '0);
         chk("rst_rsp_valid", W'(rsp_valid), '0);
         chk("rst_init_busy", W'(init_busy), '0);
         chk("rst_init_done", W'(init_done), '0);
         chk("rst_sram_ceb",  W'(sram_ceb),  W'(1));
         chk("rst_sram_web",  W'(sram_web),  W'(1));
         chk("rst_sram_a",    W'(sram_a),    '0);
         chk("rst_sram_d",    sram_d,        '0);
         chk("rst_sram_m",    sram_m,        '0);
         exp_q.delete();
         fill_left = 0;
         done_flag = 1'b0;
      end else begin
         er = (fill_left == 0) && !init_start && (req_write || (exp_q.size() < RD));
         ev = (exp_q.size() > 0) && (exp_q[0].vfrom <= cyc);
         hs = req_valid && er;
         chk("req_ready", W'(req_ready), W'(er));
         chk("rsp_valid", W'(rsp_valid), W'(ev));
         if (ev) chk("rsp_rdata", rsp_rdata, exp_q[0].data);
         chk("init_busy", W'(init_busy), W'(fill_left > 0));
         chk("init_done", W'(init_done), W'(done_flag));
         if (fill_left > 0) begin
            chk("fill_ceb", W'(sram_ceb), '0);
            chk("fill_web", W'(sram_web), '0);
            chk("fill_a",   W'(sram_a),   W'(NR - fill_left));
            chk("fill_d",   sram_d,       '0);
            chk("fill_m",   sram_m,       '1);
         end else if (hs) begin
            chk("acc_ceb", W'(sram_ceb), '0);
            chk("acc_web", W'(sram_web), W'(!req_write));
            chk("acc_a",   W'(sram_a),   W'(req_addr));
            chk("acc_d",   sram_d,       req_wdata);
            chk("acc_m",   sram_m,       req_mask);
         end else begin
            chk("noacc_ceb", W'(sram_ceb), W'(1));
            chk("noacc_web", W'(sram_web), W'(1));
         end
         // advance to the state after the coming edge
         if (ev && rsp_ready) begin
            got_q.push_back(rsp_rdata);
            void'(exp_q.pop_front());
         end
         ended = 1'b0;
         if (fill_left > 0) begin
            gold[NR - fill_left] = '0;
            fill_left--;
            ended = (fill_left == 0);
         end else if (init_start) begin
            fill_left = NR;
         end else if (hs) begin
            if (req_write) begin
               gold[req_addr] = (gold[req_addr] & ~req_mask) | (req_wdata & req_mask);
            end else begin
               e.data  = gold[req_addr];
               e.vfrom = cyc + 2;
               exp_q.push_back(e);
            end
         end
         done_flag = ended;
      end
   endtask

   initial begin
      forever begin
         @(negedge CLK);
         cyc++;
         model_step();
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_req(input bit w, input logic [AW-1:0] a,
                         input logic [W-1:0] d, input logic [W-1:0] m);
      bit ok;
      ok = 1'b0;
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      req_mask  = m;
      for (int i = 0; i < 64 && !ok; i++) begin
         @(negedge CLK);
         ok = req_ready;
         tick();
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL req_timeout addr=%0d write=%0b never accepted (required within 64 cycles)", a, w);
      end
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int n);
      for (int i = 0; i < 64 && got_q.size() < n; i++) tick();
      if (got_q.size() < n) begin
         checks++;
         errors++;
         $display("FAIL rsp_timeout got=%0d required=%0d responses", got_q.size(), n);
      end
   endtask

   function automatic logic [W-1:0] got_at(input int i);
      if (i < got_q.size()) return got_q[i];
      return 'x;
   endfunction

   initial begin
      int busy_n, done_n, acc_at;
      RST        = 1'b1;
      init_start = 1'b0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      req_mask   = '0;
      rsp_ready  = 1'b1;
      repeat (3) tick();
      RST = 1'b0;
      tick();

      // 1: full write then read, two-cycle response latency
      do_req(1'b1, 4'd3, 32'hA5A5A5A5, '1);
      do_req(1'b0, 4'd3, '0, '0);
      @(negedge CLK);
      chk("t1_lat_cycle1", W'(rsp_valid), '0);
      @(negedge CLK);
      chk("t1_lat_cycle2", W'(rsp_valid), W'(1));
      tick();
      wait_rsp(1);
      chk("t1_data", got_at(0), 32'hA5A5A5A5);

      // 2: masked write clears only the low byte
      do_req(1'b1, 4'd5, '1, '1);
      do_req(1'b1, 4'd5, '0, 32'h000000FF);
      do_req(1'b0, 4'd5, '0, '0);
      wait_rsp(2);
      chk("t2_masked", got_at(1), 32'hFFFFFF00);

      // ordering: read-then-write sees old data, write-then-read sees new
      do_req(1'b1, 4'd7, 32'h12345678, '1);
      do_req(1'b0, 4'd7, '0, '0);
      do_req(1'b1, 4'd7, 32'hCAFEF00D, '1);
      do_req(1'b0, 4'd7, '0, '0);
      wait_rsp(4);
      chk("t2_read_before_write", got_at(2), 32'h12345678);
      chk("t2_write_before_read", got_at(3), 32'hCAFEF00D);

      // 3: credit limit with a stalled consumer
      tick();
      rsp_ready = 1'b0;
      do_req(1'b0, 4'd3, '0, '0);
      do_req(1'b0, 4'd5, '0, '0);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 4'd7;
      @(negedge CLK);
      chk("t3_full_a", W'(req_ready), '0);
      tick();
      @(negedge CLK);
      chk("t3_full_b", W'(req_ready), '0);
      tick();
      rsp_ready = 1'b1;
      @(negedge CLK);
      chk("t3_pop_no_credit", W'(req_ready), '0);
      tick();
      rsp_ready = 1'b0;
      @(negedge CLK);
      chk("t3_accept_after_pop", W'(req_ready), W'(1));
      tick();
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      wait_rsp(7);
      chk("t3_order0", got_at(4), 32'hA5A5A5A5);
      chk("t3_order1", got_at(5), 32'hFFFFFF00);
      chk("t3_order2", got_at(6), 32'hCAFEF00D);

      // 4: zero-fill of all rows
      tick();
      init_start = 1'b1;
      busy_n = 0;
      done_n = 0;
      for (int i = 0; i < 24; i++) begin
         @(negedge CLK);
         busy_n += int'(init_busy);
         done_n += int'(init_done);
         tick();
         init_start = 1'b0;
      end
      chk("t4_busy_cycles", W'(busy_n), W'(16));
      chk("t4_done_pulses", W'(done_n), W'(1));
      for (int r = 0; r < NR; r++) do_req(1'b0, AW'(r), '0, '0);
      wait_rsp(7 + NR);
      for (int r = 0; r < NR; r++) chk($sformatf("t4_zero_row%0d", r), got_at(7 + r), '0);

      // 5: init_start wins over a same-cycle write
      tick();
      init_start = 1'b1;
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_addr   = 4'd9;
      req_wdata  = 32'h0BADBEEF;
      req_mask   = '1;
      @(negedge CLK);
      chk("t5_ready_blocked", W'(req_ready), '0);
      tick();
      init_start = 1'b0;
      acc_at = 0;
      for (int i = 1; i < 40 && acc_at == 0; i++) begin
         @(negedge CLK);
         if (req_ready) acc_at = i;
         tick();
      end
      req_valid = 1'b0;
      chk("t5_accept_cycle", W'(acc_at), W'(17));
      do_req(1'b0, 4'd9, '0, '0);
      wait_rsp(24);
      chk("t5_data", got_at(23), 32'h0BADBEEF);

      // 6: reset in the middle of a fill with a response buffered
      rsp_ready = 1'b0;
      do_req(1'b0, 4'd9, '0, '0);
      tick();
      tick();
      init_start = 1'b1;
      tick();
      init_start = 1'b0;
      repeat (7) tick();
      chk("t6_pre_rsp_valid", W'(rsp_valid), W'(1));
      chk("t6_pre_fill_a",    W'(sram_a),    W'(7));
      RST = 1'b1;
      #1;
      chk("t6_rst_ceb",       W'(sram_ceb),  W'(1));
      chk("t6_rst_rsp_valid", W'(rsp_valid), '0);
      chk("t6_rst_init_busy", W'(init_busy), '0);
      tick();
      tick();
      RST = 1'b0;
      done_n = 0;
      for (int i = 0; i < 24; i++) begin
         @(negedge CLK);
         done_n += int'(init_done);
         tick();
      end
      chk("t6_no_init_done", W'(done_n), '0);
      @(negedge CLK);
      chk("t6_idle_ready", W'(req_ready), W'(1));
      tick();
      rsp_ready = 1'b1;
      do_req(1'b0, 4'd9, '0, '0);
      wait_rsp(25);
      chk("t6_sram_untouched", got_at(24), 32'h0BADBEEF);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
